// File: rtl/memaccess_sequencer.sv
// Data-memory port sequencer for the LC3 MemAccess stage: turns LD/ST/LDI/STI into one or
// two valid/ack memory transactions with wait-state support and a bounded-wait timeout.
module memaccess_sequencer #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] M_Addr,
   input  logic [DATA_W-1:0] M_Data,
   input  logic [DATA_W-1:0] DMem_dout,
   input  logic              DMem_ack,
   output logic              DMem_en,
   output logic              DMem_rd,
   output logic [ADDR_W-1:0] DMem_addr,
   output logic [DATA_W-1:0] DMem_din,
   output logic [1:0]        mem_state,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] memout
);

   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IND,
      S_RD,
      S_WR,
      S_FIN
   } state_e;

   state_e            state_q, state_d;
   logic              store_q, store_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] memOut_q, memOut_d;
   logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
   logic              err_q, err_d;
   logic              accessActive;

   assign accessActive = (state_q == S_IND) || (state_q == S_RD) || (state_q == S_WR);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         store_q   <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         memOut_q  <= '0;
         waitCnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         store_q   <= store_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         memOut_q  <= memOut_d;
         waitCnt_q <= waitCnt_d;
         err_q     <= err_d;
      end
   end

   // An ack on the last permitted wait cycle wins over the timeout.
   always_comb begin
      state_d   = state_q;
      store_d   = store_q;
      addr_d    = addr_q;
      din_d     = din_q;
      memOut_d  = memOut_q;
      waitCnt_d = waitCnt_q;
      err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               store_d   = op[0];
               addr_d    = M_Addr;
               din_d     = M_Data;
               waitCnt_d = '0;
               case (op)
                  2'b00:   state_d = S_RD;
                  2'b01:   state_d = S_WR;
                  default: state_d = S_IND;
               endcase
            end
         end
         S_IND, S_RD, S_WR: begin
            if (DMem_ack) begin
               waitCnt_d = '0;
               if (state_q == S_IND) begin
                  addr_d  = ADDR_W'(DMem_dout);
                  state_d = store_q ? S_WR : S_RD;
               end else begin
                  if (state_q == S_RD) begin
                     memOut_d = DMem_dout;
                  end
                  state_d = S_FIN;
               end
            end else if (waitCnt_q == LAST_WAIT) begin
               waitCnt_d = '0;
               err_d     = 1'b1;
               state_d   = S_FIN;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         S_FIN: begin
            waitCnt_d = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_state = 2'd3;
      DMem_rd   = 1'b0;
      case (state_q)
         S_IND: begin
            mem_state = 2'd1;
            DMem_rd   = 1'b1;
         end
         S_RD: begin
            mem_state = 2'd0;
            DMem_rd   = 1'b1;
         end
         S_WR:    mem_state = 2'd2;
         default: mem_state = 2'd3;
      endcase
   end

   assign DMem_en   = accessActive;
   assign DMem_addr = addr_q;
   assign DMem_din  = din_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign err       = err_q;
   assign memout    = memOut_q;

endmodule

// File: tb/tb_memaccess_sequencer.sv
// Bench for memaccess_sequencer: a wait-state memory responder, a transaction-level model
// that predicts the per-cycle output trace, and one negedge compare process.
module tb_memaccess_sequencer;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 16;
   localparam int MAX_WAIT = 15;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        op = 2'b00;
   logic [ADDR_W-1:0] M_Addr = '0;
   logic [DATA_W-1:0] M_Data = '0;
   logic [DATA_W-1:0] DMem_dout = '0;
   logic              DMem_ack = 1'b0;
   logic              DMem_en;
   logic              DMem_rd;
   logic [ADDR_W-1:0] DMem_addr;
   logic [DATA_W-1:0] DMem_din;
   logic [1:0]        mem_state;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] memout;

   typedef struct {
      logic        en;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
      logic [1:0]  ms;
      logic        busy;
      logic        done;
      logic        err;
      logic [15:0] memout;
   } exp_t;

   exp_t        expQ[$];
   logic [15:0] mem [0:65535];
   logic [15:0] modelMemout = '0;
   int          ackWaits = 0;
   int          accCycle = 0;
   bit          newAccess = 1'b1;
   bit          inReset = 1'b1;
   int          errors = 0;
   int          checks = 0;

   memaccess_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .op(op),
      .M_Addr(M_Addr), .M_Data(M_Data), .DMem_dout(DMem_dout), .DMem_ack(DMem_ack),
      .DMem_en(DMem_en), .DMem_rd(DMem_rd), .DMem_addr(DMem_addr), .DMem_din(DMem_din),
      .mem_state(mem_state), .busy(busy), .done(done), .err(err), .memout(memout)
   );

   always #5 clock = ~clock;

   // Memory responder: acks each access after ackWaits wait cycles (negative = never).
   always @(negedge clock) begin
      if (DMem_en) begin
         if (newAccess) accCycle = 0;
         else accCycle = accCycle + 1;
         DMem_ack  = (ackWaits >= 0) && (accCycle == ackWaits);
         DMem_dout = mem[DMem_addr];
      end else begin
         DMem_ack  = 1'b0;
         DMem_dout = '0;
      end
      newAccess = !DMem_en || DMem_ack;
   end

   always @(posedge clock) begin
      if (reset_n && DMem_en && DMem_ack && !DMem_rd) mem[DMem_addr] <= DMem_din;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, act, req);
      end
   endtask

   function automatic exp_t idleEntry(input logic [15:0] mo);
      exp_t e;
      e = '{en: 1'b0, rd: 1'b0, addr: 16'h0, din: 16'h0, ms: 2'd3,
            busy: 1'b0, done: 1'b0, err: 1'b0, memout: mo};
      return e;
   endfunction

   // One access lasts waits+1 cycles, or MAX_WAIT cycles if the ack would come too late.
   function automatic bit pushAccess(input logic rd, input logic [15:0] a, input logic [15:0] d,
                                     input logic [1:0] ms, input int w);
      exp_t e;
      int   n;
      bit   timedOut;
      timedOut = (w < 0) || (w >= MAX_WAIT);
      n = timedOut ? MAX_WAIT : w + 1;
      e = '{en: 1'b1, rd: rd, addr: a, din: d, ms: ms,
            busy: 1'b1, done: 1'b0, err: 1'b0, memout: modelMemout};
      for (int i = 0; i < n; i++) expQ.push_back(e);
      return timedOut;
   endfunction

   function automatic void buildExpect(input logic [1:0] o, input logic [15:0] a,
                                       input logic [15:0] d, input int w);
      bit          to;
      logic [15:0] ptr;
      exp_t        fin;
      expQ.push_back(idleEntry(modelMemout));
      case (o)
         2'b00: begin
            to = pushAccess(1'b1, a, d, 2'd0, w);
            if (!to) modelMemout = mem[a];
         end
         2'b01: to = pushAccess(1'b0, a, d, 2'd2, w);
         default: begin
            to = pushAccess(1'b1, a, d, 2'd1, w);
            if (!to) begin
               ptr = mem[a];
               if (o == 2'b10) begin
                  to = pushAccess(1'b1, ptr, d, 2'd0, w);
                  if (!to) modelMemout = mem[ptr];
               end else begin
                  to = pushAccess(1'b0, ptr, d, 2'd2, w);
               end
            end
         end
      endcase
      fin = '{en: 1'b0, rd: 1'b0, addr: 16'h0, din: 16'h0, ms: 2'd3,
              busy: 1'b1, done: 1'b1, err: to, memout: modelMemout};
      expQ.push_back(fin);
   endfunction

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() > 0) e = expQ.pop_front();
      else e = idleEntry(modelMemout);
      check("DMem_en", 32'(DMem_en), 32'(e.en));
      check("mem_state", 32'(mem_state), 32'(e.ms));
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
      check("err", 32'(err), 32'(e.err));
      check("memout", 32'(memout), 32'(e.memout));
      if (e.en) begin
         check("DMem_rd", 32'(DMem_rd), 32'(e.rd));
         check("DMem_addr", 32'(DMem_addr), 32'(e.addr));
         if (!e.rd) check("DMem_din", 32'(DMem_din), 32'(e.din));
      end
   endtask

   always @(negedge clock) begin
      if (!inReset) checkOutput();
   end

   task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                                input int w, input int hold);
      int guard;
      @(posedge clock);
      #1;
      op = o;
      M_Addr = a;
      M_Data = d;
      ackWaits = w;
      start = 1'b1;
      buildExpect(o, a, d, w);
      repeat (hold) begin
         @(posedge clock);
         #1;
      end
      start = 1'b0;
      op = 2'b00;
      M_Addr = 16'hFFFF;
      M_Data = 16'hDEAD;
      guard = 0;
      while (expQ.size() > 0 && guard < 300) begin
         @(negedge clock);
         #1;
         guard++;
      end
      if (expQ.size() > 0) begin
         check("transaction_drain", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   task automatic checkResetOutputs();
      check("rst_DMem_en", 32'(DMem_en), 32'd0);
      check("rst_DMem_rd", 32'(DMem_rd), 32'd0);
      check("rst_DMem_addr", 32'(DMem_addr), 32'd0);
      check("rst_DMem_din", 32'(DMem_din), 32'd0);
      check("rst_mem_state", 32'(mem_state), 32'd3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_memout", 32'(memout), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h3010] = 16'hBEEF;
      mem[16'h3000] = 16'h5000;
      mem[16'h5000] = 16'h00AA;
      mem[16'h3001] = 16'h6000;
      mem[16'h2000] = 16'h1111;
      mem[16'h3002] = 16'h6100;

      repeat (2) @(posedge clock);
      #1;
      checkResetOutputs();
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      inReset = 1'b0;

      applyStimulus(2'b00, 16'h3010, 16'h0000, 0, 1);
      check("ld_memout", 32'(memout), 32'h0000BEEF);

      applyStimulus(2'b01, 16'h4000, 16'h1234, 3, 1);
      #2;
      check("st_mem_written", 32'(mem[16'h4000]), 32'h00001234);
      check("st_memout_kept", 32'(memout), 32'h0000BEEF);

      applyStimulus(2'b10, 16'h3000, 16'h0000, 0, 1);
      check("ldi_memout", 32'(memout), 32'h000000AA);

      applyStimulus(2'b11, 16'h3001, 16'h7777, 0, 1);
      #2;
      check("sti_mem_written", 32'(mem[16'h6000]), 32'h00007777);
      check("sti_memout_kept", 32'(memout), 32'h000000AA);

      applyStimulus(2'b00, 16'h3010, 16'h0000, -1, 1);
      check("timeout_memout_kept", 32'(memout), 32'h000000AA);
      applyStimulus(2'b00, 16'h2000, 16'h0000, 1, 1);
      check("after_timeout_memout", 32'(memout), 32'h00001111);

      applyStimulus(2'b00, 16'h3010, 16'h0000, MAX_WAIT - 1, 1);
      check("last_wait_ack_memout", 32'(memout), 32'h0000BEEF);
      applyStimulus(2'b00, 16'h2000, 16'h0000, MAX_WAIT, 1);
      check("late_ack_memout", 32'(memout), 32'h0000BEEF);

      applyStimulus(2'b00, 16'h2000, 16'h0000, 0, 3);
      check("held_start_memout", 32'(memout), 32'h00001111);

      applyStimulus(2'b10, 16'h3000, 16'h0000, 2, 1);
      applyStimulus(2'b10, 16'h3000, 16'h0000, -1, 1);
      check("ldi_timeout_memout", 32'(memout), 32'h000000AA);

      // STI with two waits per access: IND in cycles 1-3, WR from cycle 4; reset in cycle 5.
      @(posedge clock);
      #1;
      op = 2'b11;
      M_Addr = 16'h3002;
      M_Data = 16'h9999;
      ackWaits = 2;
      start = 1'b1;
      buildExpect(2'b11, 16'h3002, 16'h9999, 2);
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      inReset = 1'b1;
      reset_n = 1'b0;
      #1;
      checkResetOutputs();
      expQ.delete();
      modelMemout = '0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      inReset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("reset_no_write", 32'(mem[16'h6100]), 32'h00000000);

      applyStimulus(2'b00, 16'h3010, 16'h0000, 0, 1);
      check("post_reset_ld_memout", 32'(memout), 32'h0000BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memaccess_sequencer.md
Name: memaccess_sequencer

Overview:
- Sequences the LC3 data-memory port on behalf of the MemAccess stage.
- Executes LD/LDR, ST/STR, LDI and STI as one or two memory transactions, using a valid/ack handshake that allows wait states.
- Drives the mem_state encoding consumed by the memaccess datapath and reports completion, load data and timeout.
- Sits between the pipeline controller (start/op) and the data memory (DMem_*).

Parameters:
ADDR_W, 16, data-memory address width
DATA_W, 16, data width
MAX_WAIT, 15, max cycles DMem_en may stay high without DMem_ack before abort (1..255)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
op  input  2  00 LD/LDR, 01 ST/STR, 10 LDI, 11 STI
M_Addr  input  ADDR_W  effective address (pointer address for LDI/STI)
M_Data  input  DATA_W  store data
DMem_dout  input  DATA_W  memory read data, valid with DMem_ack
DMem_ack  input  1  memory completes current access this cycle
DMem_en  output  1  access request valid
DMem_rd  output  1  1 read, 0 write
DMem_addr  output  ADDR_W  access address
DMem_din  output  DATA_W  write data
mem_state  output  2  0 read, 1 indirect-pointer read, 2 write, 3 idle
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle timeout pulse, coincident with done
memout  output  DATA_W  last load result

Behaviour:
- Reset (async assert, synchronous-to-clock deassert): state IDLE. Outputs: busy 0, done 0, err 0, memout 0, DMem_en 0, DMem_rd 0, DMem_addr 0, DMem_din 0, mem_state 3.
- Reset mid-transaction: the transaction is dropped with no done pulse, and DMem_en falls immediately.
- States and mem_state values:
  - IDLE (3)
  - IND (1): read pointer at M_Addr, DMem_rd=1
  - RD (0): DMem_rd=1
  - WR (2): DMem_rd=0, DMem_din=latched M_Data
  - FIN (3)
- IDLE and start=1: latch op, M_Addr and M_Data. Next state by op:
  - 00 -> RD, addr=M_Addr
  - 01 -> WR, addr=M_Addr
  - 10 or 11 -> IND, addr=M_Addr
- Inputs are sampled only at acceptance. start while busy is ignored and not queued.
- DMem_en=1 in IND, RD and WR. DMem_addr, DMem_rd and DMem_din stay stable until the access completes.
- An access completes on the edge where DMem_en=1 and DMem_ack=1. DMem_ack is ignored while DMem_en=0.
- On completion:
  - IND: latch pointer=DMem_dout; go to RD (op 10) or WR (op 11) with addr=pointer. DMem_en stays high across the boundary, so back-to-back accesses have no bubble.
  - RD: memout<=DMem_dout; go to FIN.
  - WR: go to FIN; memout unchanged.
- FIN: done=1 for exactly one cycle, DMem_en=0, then IDLE. start during FIN is ignored; a new start is accepted the cycle after done.
- Latency with zero wait states (start sampled at edge 0):
  - LD/ST: done high in cycle 2.
  - LDI/STI: done high in cycle 3.
  - Each wait cycle adds 1.
- Wait counter (width clog2(MAX_WAIT+1)):
  - clears on every state entry and on each completion;
  - increments each cycle DMem_en=1 and DMem_ack=0.
- Timeout: when the counter reaches MAX_WAIT with no ack, go to FIN with err=1 and done=1. memout is unchanged and the remaining access of an indirect op is not issued. An ack arriving on the same edge as the counter reaching MAX_WAIT counts as completion, not a timeout.
- busy is registered, high from the cycle after acceptance through FIN inclusive.
- memout holds its value until the next successful read completion (LD, LDI), or reset.

Test Plan:
- LD, M_Addr=0x3010, memory ack same cycle with dout=0xBEEF -> DMem_en/DMem_rd/addr=0x3010 for 1 cycle, mem_state=0; done at cycle 2; memout=0xBEEF.
- ST, M_Addr=0x4000, M_Data=0x1234, ack after 3 wait cycles -> DMem_en high 4 cycles, DMem_rd=0, din=0x1234 stable, mem_state=2; done at cycle 5; memout unchanged.
- LDI, M_Addr=0x3000; mem[0x3000]=0x5000, mem[0x5000]=0x00AA; zero wait -> mem_state 1 then 0; addr 0x3000 then 0x5000 with no en gap; done at cycle 3; memout=0x00AA.
- STI, M_Addr=0x3001; mem[0x3001]=0x6000; M_Data=0x7777 -> second access is a write at 0x6000 with din=0x7777; memout unchanged.
- LD, ack never asserted, MAX_WAIT=15 -> after 15 en-high cycles, done=err=1 for one cycle; en drops; memout keeps its previous value; a following start is accepted normally.
- Also cover:
  - reset_n pulsed low during the WR of an STI -> all outputs at reset values immediately, no done pulse;
  - start held high through a whole LD -> exactly one transaction until the FIN cycle passes.
